// File: rtl/alu_pkg.sv
// Shared types and constants for the arbitrated ALU slice.
// Opcode values define the alu operation set; state_t is the arbiter FSM encoding.
// Pure declarations: no logic, no latency, no flow control.
package alu_pkg;

    localparam int OPCODE_W = 5;
    localparam int DATA_W   = 32;
    localparam int SH_W     = $clog2(DATA_W);

    localparam logic [OPCODE_W-1:0] OP_ADD  = 5'd0;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 5'd1;
    localparam logic [OPCODE_W-1:0] OP_MULS = 5'd2;
    localparam logic [OPCODE_W-1:0] OP_MULU = 5'd3;
    localparam logic [OPCODE_W-1:0] OP_AND  = 5'd4;
    localparam logic [OPCODE_W-1:0] OP_OR   = 5'd5;
    localparam logic [OPCODE_W-1:0] OP_XOR  = 5'd6;
    localparam logic [OPCODE_W-1:0] OP_SLL  = 5'd7;
    localparam logic [OPCODE_W-1:0] OP_SRL  = 5'd8;
    localparam logic [OPCODE_W-1:0] OP_SRA  = 5'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [DATA_W-1:0]   a;
        logic [DATA_W-1:0]   b;
        logic                cin;
    } op_t;

    typedef struct packed {
        logic [DATA_W-1:0] lo;
        logic [DATA_W-1:0] hi;
        logic              carry;
        logic              overflow;
        logic              zero;
    } res_t;

endpackage

// File: rtl/alu.sv
// 32-bit ALU producing a 64-bit {result1,result0} plus carry/overflow/zero.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module alu
    import alu_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic                cin,
    output logic [DATA_W-1:0]   result0,
    output logic [DATA_W-1:0]   result1,
    output logic                carry,
    output logic                overflow,
    output logic                zero
);

    logic [DATA_W:0]     sum;
    logic [2*DATA_W-1:0] wide;

    always_comb begin
        sum      = '0;
        wide     = '0;
        result0  = '0;
        result1  = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (opcode)
            OP_ADD: begin
                sum      = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
                result0  = sum[DATA_W-1:0];
                carry    = sum[DATA_W];
                overflow = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
            end
            // a - b - cin; carry set means no borrow
            OP_SUB: begin
                sum      = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, ~cin};
                result0  = sum[DATA_W-1:0];
                carry    = sum[DATA_W];
                overflow = (a[DATA_W-1] != b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
            end
            OP_MULS: begin
                wide     = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};
                result0  = wide[DATA_W-1:0];
                result1  = wide[2*DATA_W-1:DATA_W];
                overflow = wide[2*DATA_W-1:DATA_W] != {DATA_W{wide[DATA_W-1]}};
            end
            OP_MULU: begin
                wide    = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
                result0 = wide[DATA_W-1:0];
                result1 = wide[2*DATA_W-1:DATA_W];
                carry   = |wide[2*DATA_W-1:DATA_W];
            end
            OP_AND: result0 = a & b;
            OP_OR:  result0 = a | b;
            OP_XOR: result0 = a ^ b;
            // bits shifted out of the low word land in result1
            OP_SLL: begin
                wide    = {{DATA_W{1'b0}}, a} << b[SH_W-1:0];
                result0 = wide[DATA_W-1:0];
                result1 = wide[2*DATA_W-1:DATA_W];
            end
            OP_SRL: result0 = a >> b[SH_W-1:0];
            OP_SRA: result0 = $signed(a) >>> b[SH_W-1:0];
            default: ;
        endcase
        zero = ~|{result1, result0};
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted req strictly after index last, wrapping.
// Latency: purely combinational.
// Backpressure: none; grant is only meaningful when gnt_vld is high.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_vld
);

    int idx;

    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        // scan last+1 .. last+NUM_REQ so the previous winner is checked last
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (!gnt_vld && req[idx[ID_W-1:0]]) begin
                gnt_vld                = 1'b1;
                gnt[idx[ID_W-1:0]]     = 1'b1;
                gnt_id                 = idx[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one alu among NUM_REQ requesters, id-tagged responses.
// Latency: handshake in cycle N -> rsp_valid from N+2; one op per 3 cycles max.
// Backpressure: response held stable until rsp_ready; no request accepted meanwhile.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*OPCODE_W-1:0]  req_opcode,
    input  logic [NUM_REQ*DATA_W-1:0]    req_a,
    input  logic [NUM_REQ*DATA_W-1:0]    req_b,
    input  logic [NUM_REQ-1:0]           req_cin,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [ID_W-1:0]              rsp_id,
    output logic [DATA_W-1:0]            rsp_lo,
    output logic [DATA_W-1:0]            rsp_hi,
    output logic                         rsp_carry,
    output logic                         rsp_overflow,
    output logic                         rsp_zero
);

    state_t              state;
    logic [ID_W-1:0]     last;
    logic [ID_W-1:0]     op_id;
    op_t                 op_q;
    op_t                 sel_op;
    res_t                rsp_q;

    logic [NUM_REQ-1:0]  gnt;
    logic [ID_W-1:0]     gnt_id;
    logic                gnt_vld;

    logic [DATA_W-1:0]   alu_lo;
    logic [DATA_W-1:0]   alu_hi;
    logic                alu_carry;
    logic                alu_overflow;
    logic                alu_zero;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req     (req_valid),
        .last    (last),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld)
    );

    assign req_ready = (state == IDLE) ? gnt : '0;

    always_comb begin
        sel_op = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_op.opcode = req_opcode[i*OPCODE_W +: OPCODE_W];
                sel_op.a      = req_a[i*DATA_W +: DATA_W];
                sel_op.b      = req_b[i*DATA_W +: DATA_W];
                sel_op.cin    = req_cin[i];
            end
        end
    end

    alu u_alu (
        .opcode   (op_q.opcode),
        .a        (op_q.a),
        .b        (op_q.b),
        .cin      (op_q.cin),
        .result0  (alu_lo),
        .result1  (alu_hi),
        .carry    (alu_carry),
        .overflow (alu_overflow),
        .zero     (alu_zero)
    );

    // last resets to NUM_REQ-1 so requester 0 is first in line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= ID_W'(NUM_REQ - 1);
            op_id     <= '0;
            op_q      <= '0;
            rsp_q     <= '0;
            rsp_id    <= '0;
            rsp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        op_q  <= sel_op;
                        op_id <= gnt_id;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_q     <= '{lo: alu_lo, hi: alu_hi, carry: alu_carry,
                                   overflow: alu_overflow, zero: alu_zero};
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                    last      <= op_id;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rsp_lo       = rsp_q.lo;
    assign rsp_hi       = rsp_q.hi;
    assign rsp_carry    = rsp_q.carry;
    assign rsp_overflow = rsp_q.overflow;
    assign rsp_zero     = rsp_q.zero;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomised checks of alu_arbiter with NUM_REQ=4.
module tb_alu_arbiter;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -SMAX - 64'sd1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [19:0]  req_opcode;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [3:0]   req_cin;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_lo;
    logic [31:0]  rsp_hi;
    logic         rsp_carry;
    logic         rsp_overflow;
    logic         rsp_zero;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [1:0]  id;
        logic [66:0] r;
    } exp_t;

    always #5 clk = ~clk;

    alu_arbiter #(.NUM_REQ(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_opcode   (req_opcode),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_cin      (req_cin),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_lo       (rsp_lo),
        .rsp_hi       (rsp_hi),
        .rsp_carry    (rsp_carry),
        .rsp_overflow (rsp_overflow),
        .rsp_zero     (rsp_zero)
    );

    // Reference ALU: {hi, lo, carry, overflow, zero}
    function automatic logic [66:0] alu_model(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic cin);
        logic [31:0] lo, hi;
        logic c, v;
        longint s;
        logic [63:0] w;
        lo = '0; hi = '0; c = 1'b0; v = 1'b0; s = 0; w = '0;
        case (op)
            5'd0: begin
                w  = {32'd0, a} + {32'd0, b} + {63'd0, cin};
                lo = w[31:0];
                c  = w[32];
                s  = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
                v  = (s > SMAX) || (s < SMIN);
            end
            5'd1: begin
                lo = a - b - {31'd0, cin};
                c  = ({32'd0, a} >= ({32'd0, b} + {63'd0, cin}));
                s  = longint'($signed(a)) - longint'($signed(b)) - longint'(cin);
                v  = (s > SMAX) || (s < SMIN);
            end
            5'd2: begin
                s        = longint'($signed(a)) * longint'($signed(b));
                {hi, lo} = s;
                v        = (s > SMAX) || (s < SMIN);
            end
            5'd3: begin
                w        = {32'd0, a} * {32'd0, b};
                {hi, lo} = w;
                c        = (hi != 32'd0);
            end
            5'd4: lo = a & b;
            5'd5: lo = a | b;
            5'd6: lo = a ^ b;
            5'd7: begin
                w        = {32'd0, a} << b[4:0];
                {hi, lo} = w;
            end
            5'd8: lo = a >> b[4:0];
            5'd9: lo = $signed(a) >>> b[4:0];
            default: ;
        endcase
        return {hi, lo, c, v, ({hi, lo} == 64'd0)};
    endfunction

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hffff_ffff;
            2: return 32'h8000_0000;
            3: return 32'h7fff_ffff;
            default: return $urandom;
        endcase
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic c);
        req_opcode[i*5 +: 5]  = op;
        req_a[i*32 +: 32]     = a;
        req_b[i*32 +: 32]     = b;
        req_cin[i]            = c;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({rsp_valid, rsp_id, rsp_lo, rsp_hi, rsp_carry, rsp_overflow, rsp_zero} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b id=%0d lo=%h hi=%h flags=%b%b%b, want all 0",
                     rsp_valid, rsp_id, rsp_lo, rsp_hi, rsp_carry, rsp_overflow, rsp_zero);
        end
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready: got %b want 0000", req_ready);
        end
        rst_n = 1'b1;
        step();
        step();
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL idle_after_reset: rsp_valid=%b req_ready=%b want 0/0000", rsp_valid, req_ready);
        end
    endtask

    task automatic test_single_op();
        rsp_ready = 1'b1;
        set_req(2, 5'b00011, 32'h00ff_ffff, 32'h000e_fefe, 1'b0);
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_grant: req_ready=%b want 0100", req_ready);
        end
        step();
        req_valid = 4'b0000;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL single_exec: rsp_valid=%b req_ready=%b want 0/0000", rsp_valid, req_ready);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin
            errors++;
            $display("FAIL single_rsp_valid: valid=%b id=%0d want 1/2", rsp_valid, rsp_id);
        end
        checks++;
        if (rsp_lo !== 32'hfdf1_0102 || rsp_hi !== 32'h0000_0efe
            || {rsp_carry, rsp_overflow, rsp_zero} !== 3'b100) begin
            errors++;
            $display("FAIL single_result: lo=%h hi=%h flags=%b%b%b want fdf10102 00000efe 100",
                     rsp_lo, rsp_hi, rsp_carry, rsp_overflow, rsp_zero);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_accept: rsp_valid=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 5'd0, 32'(16*i + 1), 32'h100, 1'b0);
        req_valid = 4'b1111;
        #1;
        for (int n = 0; n < 5; n++) begin
            int e;
            e = n % 4;
            for (int t = 0; t < 4 && req_ready == 4'b0000; t++) step();
            checks++;
            if (req_ready !== 4'(1 << e)) begin
                errors++;
                $display("FAIL rr_grant%0d: req_ready=%b want %b", n, req_ready, 4'(1 << e));
            end
            step();
            if (n == 4) req_valid = 4'b0000;
            for (int t = 0; t < 4 && !rsp_valid; t++) step();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(e) || rsp_lo !== 32'(32'h101 + 16*e)) begin
                errors++;
                $display("FAIL rr_rsp%0d: valid=%b id=%0d lo=%h want 1/%0d/%h",
                         n, rsp_valid, rsp_id, rsp_lo, e, 32'(32'h101 + 16*e));
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        set_req(1, 5'd1, 32'd10, 32'd3, 1'b0);
        req_valid = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL bp_grant: req_ready=%b want 0010", req_ready);
        end
        step();
        set_req(0, 5'd0, 32'd1, 32'd1, 1'b0);
        req_valid = 4'b0001;
        step();
        for (int h = 0; h < 5; h++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_lo !== 32'd7 || rsp_hi !== 32'd0
                || {rsp_carry, rsp_overflow, rsp_zero} !== 3'b100 || req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b id=%0d lo=%h hi=%h flags=%b%b%b ready=%b want 1/1/7/0/100/0000",
                         h, rsp_valid, rsp_id, rsp_lo, rsp_hi, rsp_carry, rsp_overflow, rsp_zero, req_ready);
            end
            if (h < 4) step();
        end
        rsp_ready = 1'b1;
        step();
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL bp_release: rsp_valid=%b req_ready=%b want 0/0001", rsp_valid, req_ready);
        end
        step();
        req_valid = 4'b0000;
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_lo !== 32'd2) begin
            errors++;
            $display("FAIL bp_next_rsp: valid=%b id=%0d lo=%h want 1/0/2", rsp_valid, rsp_id, rsp_lo);
        end
        step();
    endtask

    task automatic test_fairness();
        rsp_ready = 1'b1;
        set_req(1, 5'd6, 32'hf0f0_f0f0, 32'hffff_ffff, 1'b0);
        req_valid = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL fair_first: req_ready=%b want 0010", req_ready);
        end
        step();
        set_req(3, 5'd5, 32'h1234_0000, 32'h0000_5678, 1'b0);
        req_valid = 4'b1010;
        step();
        checks++;
        if (rsp_id !== 2'd1 || rsp_lo !== 32'h0f0f_0f0f) begin
            errors++;
            $display("FAIL fair_rsp1: id=%0d lo=%h want 1/0f0f0f0f", rsp_id, rsp_lo);
        end
        step();
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL fair_req3_next: req_ready=%b want 1000", req_ready);
        end
        step();
        req_valid = 4'b0010;
        step();
        checks++;
        if (rsp_id !== 2'd3 || rsp_lo !== 32'h1234_5678) begin
            errors++;
            $display("FAIL fair_rsp3: id=%0d lo=%h want 3/12345678", rsp_id, rsp_lo);
        end
        step();
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL fair_back_to_1: req_ready=%b want 0010", req_ready);
        end
        step();
        req_valid = 4'b0000;
        step();
        step();
    endtask

    task automatic test_reset_mid_op();
        rsp_ready = 1'b1;
        set_req(0, 5'd4, 32'hffff_0000, 32'h0ff0_0ff0, 1'b0);
        set_req(2, 5'd3, 32'd2, 32'd3, 1'b0);
        req_valid = 4'b0101;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL rmid_pre_grant: req_ready=%b want 0100", req_ready);
        end
        step();
        req_valid = 4'b0000;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_lo, rsp_hi, rsp_carry, rsp_overflow, rsp_zero} !== '0) begin
            errors++;
            $display("FAIL rmid_clear: valid=%b id=%0d lo=%h hi=%h flags=%b%b%b want all 0",
                     rsp_valid, rsp_id, rsp_lo, rsp_hi, rsp_carry, rsp_overflow, rsp_zero);
        end
        step();
        rst_n = 1'b1;
        for (int t = 0; t < 3; t++) begin
            step();
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL rmid_no_rsp%0d: rsp_valid=%b want 0", t, rsp_valid);
            end
        end
        req_valid = 4'b0101;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL rmid_first_grant: req_ready=%b want 0001", req_ready);
        end
        step();
        req_valid = 4'b0000;
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_lo !== 32'h0ff0_0000) begin
            errors++;
            $display("FAIL rmid_rsp: valid=%b id=%0d lo=%h want 1/0/0ff00000", rsp_valid, rsp_id, rsp_lo);
        end
        step();
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t e;
        int grants = 0;
        int resps = 0;
        int cyc = 0;
        int onehot_bad = 0;
        logic [3:0] regen = 4'b0111;
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
        while (resps < 1000 && cyc < 30000) begin
            step();
            cyc++;
            if (grants >= 1000) req_valid = 4'b0000;
            for (int i = 0; i < 3; i++) begin
                if (grants < 1000 && (regen[i] || !req_valid[i])) begin
                    set_req(i, 5'($urandom_range(0, 15)), rnd_word(), rnd_word(), 1'($urandom_range(0, 1)));
                    req_valid[i] = ($urandom_range(0, 3) != 0);
                end
            end
            regen = 4'b0000;
            rsp_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (!$onehot0(req_ready)) onehot_bad++;
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra_rsp: id=%0d lo=%h with no outstanding request", rsp_id, rsp_lo);
                end else begin
                    e = q.pop_front();
                    if ({rsp_id, rsp_hi, rsp_lo, rsp_carry, rsp_overflow, rsp_zero} !== {e.id, e.r}) begin
                        errors++;
                        $display("FAIL rand_rsp%0d: got id=%0d hi=%h lo=%h f=%b%b%b want id=%0d hi=%h lo=%h f=%b",
                                 resps, rsp_id, rsp_hi, rsp_lo, rsp_carry, rsp_overflow, rsp_zero,
                                 e.id, e.r[66:35], e.r[34:3], e.r[2:0]);
                    end
                end
                resps++;
            end
            for (int i = 0; i < 4; i++) begin
                if (req_ready[i]) begin
                    e.id = 2'(i);
                    e.r  = alu_model(req_opcode[i*5 +: 5], req_a[i*32 +: 32], req_b[i*32 +: 32], req_cin[i]);
                    q.push_back(e);
                    grants++;
                    regen[i] = 1'b1;
                end
            end
        end
        checks++;
        if (resps != 1000 || grants != 1000 || q.size() != 0) begin
            errors++;
            $display("FAIL rand_count: resps=%0d grants=%0d pending=%0d want 1000/1000/0", resps, grants, q.size());
        end
        checks++;
        if (onehot_bad != 0) begin
            errors++;
            $display("FAIL rand_onehot: %0d cycles with multiple req_ready bits, want 0", onehot_bad);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        req_valid  = '0;
        req_opcode = '0;
        req_a      = '0;
        req_b      = '0;
        req_cin    = '0;
        rsp_ready  = 1'b0;
        test_reset();
        test_single_op();
        test_round_robin();
        test_backpressure();
        test_fairness();
        test_reset_mid_op();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
